ddr5_rcd_ca_parity_alert: RTL and testbench

RCD-side responder for the host CA stream.
- Checks even parity on every valid CA command.
- Forwards good commands to the downstream DRAM-side pipeline.
- Drops bad commands and drives the ALERT_n pulse and parity_err indication that the protocol checkers expect.
- Sits between the host CA input capture and the QCA output drivers.

---
 rtl/ddr5_rcd_pkg.sv | 21 ++
 rtl/ddr5_rcd_ca_parity_chk.sv | 15 +
 rtl/ddr5_rcd_ca_parity_alert.sv | 133 +++++++++++++
 tb/tb_ddr5_rcd_ca_parity_alert.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_rcd_pkg.sv
// Shared CA-path types for the RCD: command fields, the alert FSM encoding
// and the bundled command struct used by the forward path and the error log.
package ddr5_rcd_pkg;

  localparam int CA_CMD_W  = 7;
  localparam int CA_ADDR_W = 17;
  localparam int CA_CS_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALERT = 2'd1,
    HOLD  = 2'd2
  } alert_state_e;

  typedef struct packed {
    logic [CA_CMD_W-1:0]  cmd;
    logic [CA_ADDR_W-1:0] addr;
    logic [CA_CS_W-1:0]   cs;
  } ca_cmd_t;

endpackage

// File: rtl/ddr5_rcd_ca_parity_chk.sv
// Combinational 27-bit parity reduction over a CA command and its parity bit.
// odd=1 means the even-parity rule is violated.
module ddr5_rcd_ca_parity_chk
  import ddr5_rcd_pkg::*;
(
  input  logic [CA_CMD_W-1:0]  cmd,
  input  logic [CA_ADDR_W-1:0] addr,
  input  logic [CA_CS_W-1:0]   cs,
  input  logic                 par,
  output logic                 odd
);

  assign odd = ^{cmd, addr, cs, par};

endmodule

// File: rtl/ddr5_rcd_ca_parity_alert.sv
// RCD-side CA parity responder: forwards good commands, drops bad ones and
// drives the ALERT_n pulse, parity_err strobe, first-error log and error count.
module ddr5_rcd_ca_parity_alert
  import ddr5_rcd_pkg::*;
#(
  parameter int ALERT_PW        = 4,
  parameter bit BLOCK_AFTER_ERR = 1'b1,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ca_valid,
  input  logic [CA_CMD_W-1:0]  ca_cmd,
  input  logic [CA_ADDR_W-1:0] ca_addr,
  input  logic [CA_CS_W-1:0]   ca_cs,
  input  logic                 ca_par,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [CA_CMD_W-1:0]  out_cmd,
  output logic [CA_ADDR_W-1:0] out_addr,
  output logic [CA_CS_W-1:0]   out_cs,
  output logic                 parity_err,
  output logic                 alert_n,
  output logic                 err_log_valid,
  output logic [CA_CMD_W-1:0]  err_log_cmd,
  output logic [CA_ADDR_W-1:0] err_log_addr,
  output logic [CA_CS_W-1:0]   err_log_cs,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 busy
);

  localparam logic [7:0] PW_LOAD = 8'(ALERT_PW - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  alert_state_e   state_q, state_d;
  logic [7:0]     pcnt_q, pcnt_d;

  logic           odd_p0, bad_p0, fwd_p0, clr_ok_p0;
  ca_cmd_t        ca_p0;

  logic           vld_p1;
  ca_cmd_t        out_p1;
  logic           perr_p1;
  logic           alert_n_p1;
  logic           log_vld_p1;
  ca_cmd_t        log_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic           busy_p1;

  ddr5_rcd_ca_parity_chk u_chk (
    .cmd  (ca_cmd),
    .addr (ca_addr),
    .cs   (ca_cs),
    .par  (ca_par),
    .odd  (odd_p0)
  );

  // Stage p0: combinational classification of the incoming command
  assign ca_p0     = '{cmd: ca_cmd, addr: ca_addr, cs: ca_cs};
  assign bad_p0    = ca_valid & odd_p0;
  assign fwd_p0    = ca_valid & ~odd_p0 & (state_q == IDLE);
  assign clr_ok_p0 = err_clr & (state_q != ALERT);

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: begin
        if (bad_p0) begin
          state_d = ALERT;
          pcnt_d  = PW_LOAD;
        end
      end
      ALERT: begin
        if (pcnt_q == 8'd0) state_d = BLOCK_AFTER_ERR ? HOLD : IDLE;
        else                pcnt_d  = pcnt_q - 8'd1;
      end
      HOLD: begin
        if (err_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: all outputs registered one cycle after the command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      vld_p1     <= 1'b0;
      out_p1     <= '0;
      perr_p1    <= 1'b0;
      alert_n_p1 <= 1'b1;
      log_vld_p1 <= 1'b0;
      log_p1     <= '0;
      cnt_p1     <= '0;
      busy_p1    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      vld_p1     <= fwd_p0;
      perr_p1    <= bad_p0;
      alert_n_p1 <= (state_d != ALERT);
      busy_p1    <= (state_d != IDLE);
      if (fwd_p0) out_p1 <= ca_p0;
      if (bad_p0) cnt_p1 <= sat_inc(cnt_p1);
      // A fresh capture beats a simultaneous clear so the newest error is kept
      if (bad_p0 && (!log_vld_p1 || clr_ok_p0)) begin
        log_p1     <= ca_p0;
        log_vld_p1 <= 1'b1;
      end else if (clr_ok_p0) begin
        log_vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid     = vld_p1;
  assign out_cmd       = out_p1.cmd;
  assign out_addr      = out_p1.addr;
  assign out_cs        = out_p1.cs;
  assign parity_err    = perr_p1;
  assign alert_n       = alert_n_p1;
  assign err_log_valid = log_vld_p1;
  assign err_log_cmd   = log_p1.cmd;
  assign err_log_addr  = log_p1.addr;
  assign err_log_cs    = log_p1.cs;
  assign err_cnt       = cnt_p1;
  assign busy          = busy_p1;

endmodule

// File: tb/tb_ddr5_rcd_ca_parity_alert.sv
// Bench for the CA parity responder: two configurations share one stimulus
// table; a behavioural model plus hand-entered expectations feed a scoreboard.
module tb_ddr5_rcd_ca_parity_alert;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ca_valid, ca_par, err_clr;
  logic [6:0]  ca_cmd;
  logic [16:0] ca_addr;
  logic [1:0]  ca_cs;

  logic        ov_a, perr_a, an_a, lv_a, busy_a;
  logic [6:0]  oc_a, lc_a;
  logic [16:0] oa_a, la_a;
  logic [1:0]  ocs_a, lcs_a;
  logic [7:0]  cnt_a;

  logic        ov_b, perr_b, an_b, lv_b, busy_b;
  logic [6:0]  oc_b, lc_b;
  logic [16:0] oa_b, la_b;
  logic [1:0]  ocs_b, lcs_b;
  logic [1:0]  cnt_b;

  ddr5_rcd_ca_parity_alert #(.ALERT_PW(4), .BLOCK_AFTER_ERR(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .ca_valid(ca_valid), .ca_cmd(ca_cmd), .ca_addr(ca_addr),
    .ca_cs(ca_cs), .ca_par(ca_par), .err_clr(err_clr),
    .out_valid(ov_a), .out_cmd(oc_a), .out_addr(oa_a), .out_cs(ocs_a),
    .parity_err(perr_a), .alert_n(an_a), .err_log_valid(lv_a), .err_log_cmd(lc_a),
    .err_log_addr(la_a), .err_log_cs(lcs_a), .err_cnt(cnt_a), .busy(busy_a));

  ddr5_rcd_ca_parity_alert #(.ALERT_PW(4), .BLOCK_AFTER_ERR(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .ca_valid(ca_valid), .ca_cmd(ca_cmd), .ca_addr(ca_addr),
    .ca_cs(ca_cs), .ca_par(ca_par), .err_clr(err_clr),
    .out_valid(ov_b), .out_cmd(oc_b), .out_addr(oa_b), .out_cs(ocs_b),
    .parity_err(perr_b), .alert_n(an_b), .err_log_valid(lv_b), .err_log_cmd(lc_b),
    .err_log_addr(la_b), .err_log_cs(lcs_b), .err_cnt(cnt_b), .busy(busy_b));

  typedef struct {
    bit          rst;
    bit          valid;
    logic [6:0]  cmd;
    logic [16:0] addr;
    logic [1:0]  cs;
    bit          flip;
    bit          clr;
    bit          ep_a;
    bit          ea_a;
  } vec_t;

  typedef struct {
    int          st;
    int          left;
    bit          ov;
    logic [6:0]  oc;
    logic [16:0] oa;
    logic [1:0]  ocs;
    bit          perr;
    bit          an;
    bit          lv;
    logic [6:0]  lc;
    logic [16:0] la;
    logic [1:0]  lcs;
    int          cnt;
    bit          busy;
  } mdl_t;

  typedef struct {
    int   idx;
    mdl_t a;
    mdl_t b;
    bit   ep_a;
    bit   ea_a;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  mdl_t ma, mb;
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(bit r, bit v, logic [6:0] c, logic [16:0] a, logic [1:0] s,
                              bit f, bit cl, bit ep, bit ea);
    vec_t x;
    x.rst = r; x.valid = v; x.cmd = c; x.addr = a; x.cs = s;
    x.flip = f; x.clr = cl; x.ep_a = ep; x.ea_a = ea;
    return x;
  endfunction

  function automatic logic parbit(vec_t v);
    return (^{v.cmd, v.addr, v.cs}) ^ v.flip;
  endfunction

  // Reference behaviour: left counts remaining low alert cycles
  function automatic mdl_t step(mdl_t s, vec_t v, int pw, bit blk, int cmax);
    mdl_t n;
    bit   bad, clr_ok;
    n = s;
    if (v.rst) begin
      n = '{default: 0};
      n.an = 1'b1;
      return n;
    end
    bad    = v.valid && (^{v.cmd, v.addr, v.cs, parbit(v)});
    clr_ok = v.clr && (s.st != 1);
    n.perr = bad;
    if (bad && s.cnt < cmax) n.cnt = s.cnt + 1;
    n.ov = v.valid && !bad && (s.st == 0);
    if (n.ov) begin n.oc = v.cmd; n.oa = v.addr; n.ocs = v.cs; end
    if (bad && (!s.lv || clr_ok)) begin
      n.lv = 1'b1; n.lc = v.cmd; n.la = v.addr; n.lcs = v.cs;
    end else if (clr_ok) begin
      n.lv = 1'b0;
    end
    case (s.st)
      0: if (bad) begin n.st = 1; n.left = pw; end
      1: begin
        n.left = s.left - 1;
        if (n.left == 0) n.st = blk ? 2 : 0;
      end
      default: if (v.clr) n.st = 0;
    endcase
    n.an   = (n.st != 1);
    n.busy = (n.st != 0);
    return n;
  endfunction

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(vec_t v, int idx);
    exp_t e;
    @(negedge clk);
    rst = v.rst; ca_valid = v.valid; ca_cmd = v.cmd; ca_addr = v.addr;
    ca_cs = v.cs; ca_par = parbit(v); err_clr = v.clr;
    ma = step(ma, v, 4, 1'b1, 255);
    mb = step(mb, v, 4, 1'b0, 3);
    sb.push_back('{idx: idx, a: ma, b: mb, ep_a: v.ep_a, ea_a: v.ea_a});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", idx, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk("a_parity_err_tbl", e.idx, 64'(perr_a), 64'(e.ep_a));
    chk("a_alert_n_tbl",    e.idx, 64'(an_a),   64'(e.ea_a));
    chk("a_out_valid", e.idx, 64'(ov_a), 64'(e.a.ov));
    chk("a_out_fields", e.idx, 64'({oc_a, oa_a, ocs_a}), 64'({e.a.oc, e.a.oa, e.a.ocs}));
    chk("a_parity_err", e.idx, 64'(perr_a), 64'(e.a.perr));
    chk("a_alert_n", e.idx, 64'(an_a), 64'(e.a.an));
    chk("a_log", e.idx, 64'({lv_a, lc_a, la_a, lcs_a}), 64'({e.a.lv, e.a.lc, e.a.la, e.a.lcs}));
    chk("a_err_cnt", e.idx, 64'(cnt_a), 64'(e.a.cnt));
    chk("a_busy", e.idx, 64'(busy_a), 64'(e.a.busy));
    chk("b_out_valid", e.idx, 64'(ov_b), 64'(e.b.ov));
    chk("b_out_fields", e.idx, 64'({oc_b, oa_b, ocs_b}), 64'({e.b.oc, e.b.oa, e.b.ocs}));
    chk("b_parity_err", e.idx, 64'(perr_b), 64'(e.b.perr));
    chk("b_alert_n", e.idx, 64'(an_b), 64'(e.b.an));
    chk("b_log", e.idx, 64'({lv_b, lc_b, la_b, lcs_b}), 64'({e.b.lv, e.b.lc, e.b.la, e.b.lcs}));
    chk("b_err_cnt", e.idx, 64'(cnt_b), 64'(e.b.cnt));
    chk("b_busy", e.idx, 64'(busy_b), 64'(e.b.busy));
  endtask

  initial begin
    rst = 1'b1; ca_valid = 1'b0; ca_cmd = '0; ca_addr = '0; ca_cs = '0;
    ca_par = 1'b0; err_clr = 1'b0;
    ma = '{default: 0}; mb = '{default: 0};

    //            rst v  cmd    addr       cs  flip clr ep_a ea_a
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 7'h01, 17'h1ABCD, 2'd1, 0, 0, 0, 1));  // 4 good stream
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 7'h05, 17'h00010, 2'd0, 1, 0, 1, 0));  // 6 first error
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7'h06, 17'h00020, 2'd3, 1, 0, 1, 0));  // 8 error inside alert
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7'h0A, 17'h00100, 2'd1, 0, 0, 0, 1));  // 10 goods: A drops
    tbl.push_back(mk(0, 1, 7'h0B, 17'h00200, 2'd2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 7'h0C, 17'h00300, 2'd3, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 7'h0D, 17'h00400, 2'd0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 7'h0E, 17'h00500, 2'd1, 1, 0, 1, 1));  // 14 error in HOLD
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 1, 0, 1));  // 18 err_clr in HOLD
    tbl.push_back(mk(0, 1, 7'h0F, 17'h01000, 2'd2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 7'h11, 17'h12345, 2'd1, 1, 0, 1, 0));  // 20 new alert
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 1, 0, 0));  // 21 err_clr ignored
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 7'h33, 17'h0F0F0, 2'd2, 1, 1, 1, 1));  // 25 bad + clr in HOLD
    tbl.push_back(mk(0, 1, 7'h21, 17'h1FFFF, 2'd3, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 7'h22, 17'h00001, 2'd0, 1, 0, 1, 0));  // 28 alert then reset
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 7'h24, 17'h00002, 2'd1, 0, 0, 0, 1));  // 30 rst with good cmd
    tbl.push_back(mk(0, 1, 7'h23, 17'h0AAAA, 2'd1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 7'h00, 17'h00000, 2'd0, 0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
